// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: BRAM32k geometry and ifmap loader state encoding.
package cnn_pkg;

    localparam int unsigned BRAM_ADDR_W    = 12;
    localparam int unsigned BRAM_DATA_W    = 64;
    localparam int unsigned BYTES_PER_WORD = BRAM_DATA_W / 8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes LSB-lane first into a DATA_W word; clears after a full or terminated word.
module byte_packer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    input  logic              i_last,
    output logic              o_word_full_c,
    output logic [DATA_W-1:0] o_word_c
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] r_lane;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_ins;
    logic              w_word_full;

    // Current byte merged into the partial word so the completing byte is visible this cycle.
    always_comb begin
        w_word_ins = r_word;
        w_word_ins[int'(r_lane)*8 +: 8] = i_data;
    end

    assign w_word_full   = i_valid && (r_lane == LANE_W'(LANES - 1));
    assign o_word_full_c = w_word_full;
    assign o_word_c      = w_word_ins;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            if (w_word_full || i_last) begin
                // Zero-clear so a later partial word is padded in its unfilled lanes.
                r_lane <= '0;
                r_word <= '0;
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_word <= w_word_ins;
            end
        end
    end

endmodule

// File: rtl/ifmap_loader.sv
// Input-feature-map loader: byte stream in, packed words written to BRAM32k port A for pe1.
module ifmap_loader
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W      = BRAM_DATA_W,
    parameter int unsigned ADDR_W      = BRAM_ADDR_W,
    parameter int unsigned FRAME_WORDS = 98,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    localparam int unsigned ADDR_SPAN = 1 << ADDR_W;

    if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_data_w
        $error("ifmap_loader: DATA_W must be a multiple of 8 and at least 16");
    end
    if (FRAME_WORDS == 0 || (BASE_ADDR + FRAME_WORDS) > ADDR_SPAN) begin : g_bad_addr_range
        $error("ifmap_loader: frame does not fit in the BRAM address space");
    end

    loader_state_e     r_state;
    logic              r_s_ready;
    logic              r_bram_we;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_din;
    logic              r_busy;
    logic              r_done;
    logic              r_err_len;
    logic [ADDR_W-1:0] r_word_idx;

    logic              w_accept;
    logic              w_packer_clr;
    logic              w_word_full;
    logic [DATA_W-1:0] w_word;
    logic              w_last_word;
    logic              w_frame_end;
    logic              w_len_ok;

    // s_ready is only ever high in LOAD, so the handshake alone qualifies a byte.
    assign w_accept     = s_valid && r_s_ready;
    assign w_packer_clr = (r_state == LD_IDLE) && start;
    assign w_last_word  = (r_word_idx == ADDR_W'(FRAME_WORDS - 1));
    assign w_frame_end  = w_accept && (s_last || (w_word_full && w_last_word));
    assign w_len_ok     = s_last && w_word_full && w_last_word;

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_packer_clr),
        .i_valid       (w_accept),
        .i_data        (s_data),
        .i_last        (s_last),
        .o_word_full_c (w_word_full),
        .o_word_c      (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LD_IDLE;
            r_s_ready   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= ADDR_W'(BASE_ADDR);
            r_bram_din  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_word_idx  <= '0;
        end else begin
            r_bram_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (start) begin
                        r_state    <= LD_LOAD;
                        r_s_ready  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_err_len  <= 1'b0;
                        r_word_idx <= '0;
                    end
                end
                LD_LOAD: begin
                    // A terminating byte shares the same write path, so a full word ending early is written once.
                    if (w_accept && (w_word_full || s_last)) begin
                        r_bram_we   <= 1'b1;
                        r_bram_addr <= ADDR_W'(BASE_ADDR) + r_word_idx;
                        r_bram_din  <= w_word;
                        r_word_idx  <= r_word_idx + ADDR_W'(1);
                    end
                    if (w_frame_end) begin
                        r_state   <= LD_FLUSH;
                        r_s_ready <= 1'b0;
                        r_err_len <= !w_len_ok;
                    end
                end
                LD_FLUSH: begin
                    r_state <= LD_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                LD_DONE: begin
                    r_state <= LD_IDLE;
                end
                default: begin
                    r_state <= LD_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_ifmap_loader.sv
// Directed and randomized frames for ifmap_loader checked against a byte-list reference model.
module tb_ifmap_loader;

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 12;
    localparam int unsigned FW   = 2;
    localparam int unsigned BASE = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          busy;
    logic          done;
    logic          err_len;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] tx [32];

    logic [7:0]    acc_q  [$];
    int            acc_cyc[$];
    logic [AW-1:0] wa_q   [$];
    logic [DW-1:0] wd_q   [$];
    int            wc_q   [$];
    int            dn_q   [$];
    logic          de_q   [$];

    ifmap_loader #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .FRAME_WORDS (FW),
        .BASE_ADDR   (BASE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes, writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) begin
                acc_q.push_back(s_data);
                acc_cyc.push_back(cyc);
            end
            if (bram_we) begin
                wa_q.push_back(bram_addr);
                wd_q.push_back(bram_din);
                wc_q.push_back(cyc);
            end
            if (done) begin
                dn_q.push_back(cyc);
                de_q.push_back(err_len);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        acc_q.delete(); acc_cyc.delete();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        dn_q.delete(); de_q.delete();
    endtask

    task automatic start_frame();
        clear_q();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic fill_seq(input logic [7:0] base);
        for (int i = 0; i < 32; i++) tx[i] = base + 8'(i);
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle between bytes, 2 random idle cycles.
    task automatic send(input int n, input int last_pos, input int gap_mode, input int start_at);
        logic got;
        int   waited;
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = tx[i];
            s_last  = (i == last_pos);
            start   = (i == start_at);
            waited  = 0;
            got     = 1'b0;
            while (!got && waited < 8) begin
                @(negedge clk);
                got = s_ready;
                @(posedge clk); #1;
                start = 1'b0;
                waited++;
            end
            if (!got) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Reference: bytes are accepted until s_last or until the frame is full; words are 8-byte chunks.
    task automatic check_frame(input string name, input int n, input int last_pos);
        int          fb;
        int          acc_n;
        int          nw;
        int          li;
        logic        exp_err;
        logic [63:0] w;
        fb = int'(FW) * 8;
        if (last_pos >= 0 && last_pos < n && last_pos < fb) acc_n = last_pos + 1;
        else acc_n = (n < fb) ? n : fb;
        exp_err = !(acc_n == fb && last_pos == fb - 1);
        nw = (acc_n + 7) / 8;
        repeat (6) @(posedge clk);
        #1;
        chk($sformatf("%s.accepted", name), 64'(acc_q.size()), 64'(acc_n));
        for (int i = 0; i < acc_n && i < acc_q.size(); i++)
            chk($sformatf("%s.byte%0d", name, i), 64'(acc_q[i]), 64'(tx[i]));
        chk($sformatf("%s.nwrites", name), 64'(wa_q.size()), 64'(nw));
        for (int j = 0; j < nw && j < wa_q.size(); j++) begin
            w = '0;
            for (int b = 0; b < 8; b++)
                if (j * 8 + b < acc_n) w[8*b +: 8] = tx[j*8 + b];
            chk($sformatf("%s.addr%0d", name, j), 64'(wa_q[j]), 64'(BASE + j));
            chk($sformatf("%s.data%0d", name, j), wd_q[j], w);
            li = (j * 8 + 7 < acc_n) ? j * 8 + 7 : acc_n - 1;
            if (li < acc_cyc.size())
                chk($sformatf("%s.wcyc%0d", name, j), 64'(wc_q[j]), 64'(acc_cyc[li] + 1));
        end
        chk($sformatf("%s.ndone", name), 64'(dn_q.size()), 64'd1);
        if (dn_q.size() > 0) begin
            if (acc_n > 0 && acc_n <= acc_cyc.size())
                chk($sformatf("%s.donecyc", name), 64'(dn_q[0]), 64'(acc_cyc[acc_n-1] + 2));
            chk($sformatf("%s.err_len", name), 64'(de_q[0]), 64'(exp_err));
        end
        chk($sformatf("%s.busy_end", name), 64'(busy), 64'd0);
        chk($sformatf("%s.ready_end", name), 64'(s_ready), 64'd0);
    endtask

    task automatic chk_idle(input string name);
        chk($sformatf("%s.s_ready", name), 64'(s_ready), 64'd0);
        chk($sformatf("%s.bram_we", name), 64'(bram_we), 64'd0);
        chk($sformatf("%s.busy", name), 64'(busy), 64'd0);
        chk($sformatf("%s.done", name), 64'(done), 64'd0);
        chk($sformatf("%s.err_len", name), 64'(err_len), 64'd0);
        chk($sformatf("%s.bram_addr", name), 64'(bram_addr), 64'(BASE));
        chk($sformatf("%s.bram_din", name), bram_din, 64'd0);
    endtask

    initial begin
        int n;
        int lp;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        // Nominal frame 0x00..0x0F, last on 0x0F
        fill_seq(8'h00);
        start_frame();
        send(16, 15, 0, -1);
        check_frame("nominal", 16, 15);

        // Same frame with idle cycles between bytes
        start_frame();
        send(16, 15, 1, -1);
        check_frame("gaps", 16, 15);

        // Early s_last on the third byte
        fill_seq(8'hA0);
        start_frame();
        send(3, 2, 0, -1);
        check_frame("early_last", 3, 2);

        // Next start clears err_len
        fill_seq(8'h00);
        start_frame();
        @(negedge clk);
        chk("restart.err_len", 64'(err_len), 64'd0);
        chk("restart.busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        send(16, 15, 0, -1);
        check_frame("restart", 16, 15);

        // s_last on the 8th lane of a non-final word
        fill_seq(8'h40);
        start_frame();
        send(8, 7, 0, -1);
        check_frame("last_lane7", 8, 7);

        // Missing s_last: 18 bytes offered, only the frame's 16 consumed
        fill_seq(8'h60);
        start_frame();
        send(18, -1, 0, -1);
        check_frame("no_last", 18, -1);

        // Start pulse during LOAD is ignored
        fill_seq(8'h00);
        start_frame();
        send(16, 15, 0, 3);
        check_frame("start_busy", 16, 15);

        // Reset after 5 accepted bytes
        fill_seq(8'h30);
        start_frame();
        send(5, -1, 0, -1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset.nwrites", 64'(wa_q.size()), 64'd0);
        chk("midreset.ndone", 64'(dn_q.size()), 64'd0);
        fill_seq(8'h80);
        start_frame();
        send(16, 15, 0, -1);
        check_frame("after_reset", 16, 15);

        // Randomized frames: random bytes, lengths, termination points and gaps
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) tx[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                n  = int'($urandom_range(16, 20));
                lp = -1;
            end else begin
                n  = int'($urandom_range(1, 20));
                lp = int'($urandom_range(0, n - 1));
            end
            start_frame();
            send(n, lp, int'($urandom_range(0, 2)), -1);
            check_frame($sformatf("rand%0d", it), n, lp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifmap_loader.md
Name: ifmap_loader

Overview:
- Input-feature-map loader directly upstream of pe1.
- Accepts the input image as a byte stream over a valid/ready handshake and packs 8 bytes into each 64-bit word.
- Writes the words into BRAM32k port A (12-bit address) and signals pe1 that layer-1 input data is resident.
- Runs on the clk_wiz clk domain.

Parameters:
- DATA_W, 64, BRAM word width; must be a multiple of 8.
- ADDR_W, 12, BRAM32k address width.
- FRAME_WORDS, 98, words per frame (28x28 bytes = 784 = 98 x 8).
- BASE_ADDR, 0, BRAM address of word 0.

Ports:
- clk  in  1  system clock (clk_wiz clk_out1).
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  pixel byte.
- s_last  in  1  marks final byte of frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- bram_we  out  1  write enable to BRAM32k port A.
- bram_addr  out  ADDR_W  write address.
- bram_din  out  DATA_W  packed word.
- busy  out  1  frame load in progress.
- done  out  1  one-cycle pulse when frame fully written.
- err_len  out  1  frame length mismatch; sticky until next accepted start.

Behaviour:
- Reset: state IDLE; s_ready, bram_we, busy, done, err_len = 0; bram_addr = BASE_ADDR; bram_din = 0; byte lane and word counters = 0.
- Reset mid-frame: same values the next cycle. Words already written remain in BRAM. No flush, no done.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD on start. Clears counters and err_len.
- LOAD: s_ready = 1; busy = 1.
- FLUSH: s_ready = 0; busy = 1.
- DONE: done = 1 for exactly one cycle; busy = 0; then IDLE.
- start outside IDLE is ignored.
- Packing: the k-th accepted byte of a word (k = 0..7) goes to bits [8k+7:8k]; the first byte is the least-significant lane.
- Write timing: the byte completing a word is accepted in cycle t. In cycle t+1, bram_we = 1, bram_addr = BASE_ADDR + word_index, bram_din = packed word.
- Throughput: full, one byte per cycle. bram_we is otherwise 0.
- Frame end, normal: the byte completing word FRAME_WORDS-1 is accepted with s_last = 1. Next cycle: FLUSH, with the final write occurring in that cycle. Then DONE. done is high 2 cycles after the final byte is accepted. err_len = 0.
- Frame end, early s_last: s_last is accepted on a byte before the final byte of the frame. The partial word is zero-padded in the unfilled upper lanes and written in the FLUSH cycle. Then DONE, and err_len = 1.
- Frame end, missing s_last: the final byte of word FRAME_WORDS-1 is accepted with s_last = 0. Normal FLUSH/DONE, err_len = 1. s_ready stays 0, so further bytes are not consumed.
- Simultaneous events: s_last on the 8th lane of a non-final word is treated as early termination. That word is written unpadded in FLUSH; no duplicate write occurs.
- Addressing: word counter width is ADDR_W. BASE_ADDR + FRAME_WORDS - 1 must be ≤ 2^ADDR_W - 1 (elaboration-time assertion); no wrap-around at runtime.
- All outputs are registered.

Decomposition:
- Shared package (cnn_pkg):
  - BYTES_PER_WORD = DATA_W/8.
  - Loader state encoding (IDLE = 0, LOAD = 1, FLUSH = 2, DONE = 3).
  - BRAM32k geometry constants (ADDR_W = 12, DATA_W = 64).
- One natural sub-module, byte_packer. It holds the lane counter and the lane-insert register with zero-clear, and outputs word_full and the packed word.
- The FSM, address counter and length check stay in ifmap_loader.

Test Plan:
- Nominal frame: FRAME_WORDS = 2, BASE_ADDR = 0x010; start, then bytes 0x00..0x0F back-to-back with s_last on 0x0F. Expect:
  - Writes to 0x010 = 0x0706050403020100 and 0x011 = 0x0F0E0D0C0B0A0908.
  - Each write one cycle after its 8th byte.
  - done pulse two cycles after 0x0F is accepted; err_len = 0; exactly 2 bram_we cycles.
- Backpressure gaps: same frame with s_valid low every other cycle. Expect identical BRAM contents and addresses, and no writes during gaps.
- Early s_last: FRAME_WORDS = 2; bytes 0xA0..0xA2 with s_last on 0xA2. Expect:
  - A single write to 0x010 = 0x0000000000A2A1A0.
  - done pulse; err_len = 1.
  - A subsequent start clears err_len.
- Missing s_last: FRAME_WORDS = 1; 10 bytes offered with no s_last. Expect:
  - 8 bytes accepted, then s_ready = 0.
  - One write; done; err_len = 1.
  - Bytes 9–10 are not accepted.
- Reset mid-frame: rst asserted after 5 bytes. Expect next cycle: all outputs 0, state IDLE, no write, no done. A new start writes the next frame from BASE_ADDR.
- Start while busy: a second start pulse during LOAD. Expect no counter clear and an unchanged write sequence.
